// File: rtl/bridge_pkg.sv
// Package: bridge_pkg
// Shared constants and the APB master state type for the AHB-to-APB bridge.
//   ADDR_W  - AHB/APB address width
//   DATA_W  - AHB/APB write data width
//   NSLV    - number of APB slaves (width of the one-hot select)
//   state_e - APB master FSM states
package bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NSLV   = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WWAIT    = 3'd1,
    READ     = 3'd2,
    WRITE    = 3'd3,
    WRITEP   = 3'd4,
    RENABLE  = 3'd5,
    WENABLE  = 3'd6,
    WENABLEP = 3'd7
  } state_e;

endpackage

// File: rtl/apb_controller.sv
// Module: apb_controller
// APB master FSM of the AHB-to-APB bridge. Turns qualified AHB transfers
// (plus their pipelined address/data copies) into two-cycle APB setup/enable
// accesses and stalls the AHB side with hready_out while a setup is in flight.
// Ports:
//   hclk        - clock, all state on posedge
//   hresetn     - synchronous active-low reset
//   valid       - qualified AHB transfer in bridge range
//   hwrite      - current-cycle AHB write flag
//   hwrite_reg  - hwrite delayed two cycles
//   haddr       - current AHB address; haddr_1/haddr_2 delayed 1/2 cycles
//   hwdata      - current AHB write data; hwdata_1 delayed 1 cycle
//   tempselx    - one-hot slave decode of haddr
//   pselx, penable, pwrite, paddr, pwdata - registered APB master outputs
//   hready_out  - registered AHB ready
module apb_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = bridge_pkg::ADDR_W,
  parameter int DATA_W = bridge_pkg::DATA_W,
  parameter int NSLV   = bridge_pkg::NSLV
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwrite_reg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr_1,
  input  logic [ADDR_W-1:0] haddr_2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata_1,
  input  logic [NSLV-1:0]   tempselx,
  output logic [NSLV-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hready_out
);

  state_e              state_r;
  state_e              next_state_s;
  logic [NSLV-1:0]     sel_r;
  logic [NSLV-1:0]     sel_next_s;
  logic [NSLV-1:0]     pselx_s;
  logic                penable_s;
  logic                pwrite_s;
  logic [ADDR_W-1:0]   paddr_s;
  logic [DATA_W-1:0]   pwdata_s;
  logic                hready_s;

  // Next-state decode.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE, RENABLE, WENABLE: begin
        if (valid && hwrite) begin
          next_state_s = WWAIT;
        end else if (valid) begin
          next_state_s = READ;
        end else begin
          next_state_s = IDLE;
        end
      end
      WWAIT: begin
        if (valid) begin
          next_state_s = WRITEP;
        end else begin
          next_state_s = WRITE;
        end
      end
      READ:    next_state_s = RENABLE;
      WRITE: begin
        if (valid) begin
          next_state_s = WENABLEP;
        end else begin
          next_state_s = WENABLE;
        end
      end
      WRITEP:  next_state_s = WENABLEP;
      WENABLEP: begin
        // A pending read in the pipeline takes priority over further writes.
        if (!hwrite_reg) begin
          next_state_s = READ;
        end else if (valid) begin
          next_state_s = WRITEP;
        end else begin
          next_state_s = WRITE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Slave select capture: the decode is taken when a new read or write starts.
  always_comb begin
    if ((next_state_s == READ) || (next_state_s == WWAIT)) begin
      sel_next_s = tempselx;
    end else begin
      sel_next_s = sel_r;
    end
  end

  // Output values for the state being entered; anything not reloaded holds.
  always_comb begin
    pselx_s   = pselx;
    penable_s = penable;
    pwrite_s  = pwrite;
    paddr_s   = paddr;
    pwdata_s  = pwdata;
    hready_s  = hready_out;
    case (next_state_s)
      IDLE, WWAIT: begin
        pselx_s   = '0;
        penable_s = 1'b0;
        hready_s  = 1'b1;
      end
      READ: begin
        // Uses the select being captured this edge, not the stale one.
        pselx_s   = sel_next_s;
        penable_s = 1'b0;
        pwrite_s  = 1'b0;
        paddr_s   = haddr;
        hready_s  = 1'b0;
      end
      WRITE, WRITEP: begin
        pselx_s   = sel_next_s;
        penable_s = 1'b0;
        pwrite_s  = 1'b1;
        hready_s  = 1'b0;
        // In the pipelined path the address/data are one stage further back.
        if (state_r == WENABLEP) begin
          paddr_s  = haddr_2;
          pwdata_s = hwdata_1;
        end else begin
          paddr_s  = haddr_1;
          pwdata_s = hwdata;
        end
      end
      RENABLE, WENABLE, WENABLEP: begin
        penable_s = 1'b1;
        hready_s  = 1'b1;
      end
      default: begin
        pselx_s   = '0;
        penable_s = 1'b0;
        hready_s  = 1'b1;
      end
    endcase
  end

  // State, captured select and registered APB/AHB outputs.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_r    <= IDLE;
      sel_r      <= '0;
      pselx      <= '0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      hready_out <= 1'b1;
    end else begin
      state_r    <= next_state_s;
      sel_r      <= sel_next_s;
      pselx      <= pselx_s;
      penable    <= penable_s;
      pwrite     <= pwrite_s;
      paddr      <= paddr_s;
      pwdata     <= pwdata_s;
      hready_out <= hready_s;
    end
  end

endmodule

// File: tb/tb_apb_controller.sv
// Testbench for apb_controller: directed scenarios with constant expectations
// followed by randomized traffic checked against a behavioural model.
module tb_apb_controller;

  logic        hclk;
  logic        hresetn;
  logic        valid;
  logic        hwrite;
  logic        hwrite_reg;
  logic [31:0] haddr;
  logic [31:0] haddr_1;
  logic [31:0] haddr_2;
  logic [31:0] hwdata;
  logic [31:0] hwdata_1;
  logic [2:0]  tempselx;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hready_out;

  logic        hwrite_d1;

  int total;
  int bad;

  // behavioural model: access phase and the APB bus it implies
  localparam int M_IDLE  = 0;
  localparam int M_WWAIT = 1;
  localparam int M_READ  = 2;
  localparam int M_WRITE = 3;
  localparam int M_WRP   = 4;
  localparam int M_REN   = 5;
  localparam int M_WEN   = 6;
  localparam int M_WENP  = 7;

  int          m_st;
  logic [2:0]  m_sel;
  logic [2:0]  m_psel;
  logic        m_pen;
  logic        m_pw;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic        m_rdy;

  apb_controller dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .valid      (valid),
    .hwrite     (hwrite),
    .hwrite_reg (hwrite_reg),
    .haddr      (haddr),
    .haddr_1    (haddr_1),
    .haddr_2    (haddr_2),
    .hwdata     (hwdata),
    .hwdata_1   (hwdata_1),
    .tempselx   (tempselx),
    .pselx      (pselx),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .hready_out (hready_out)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic m_bus_idle(input int st);
    m_st = st; m_psel = 3'b000; m_pen = 1'b0; m_rdy = 1'b1;
  endtask

  task automatic m_start_read();
    m_sel = tempselx; m_st = M_READ; m_psel = tempselx; m_pen = 1'b0;
    m_pw = 1'b0; m_paddr = haddr; m_rdy = 1'b0;
  endtask

  task automatic m_write_setup(input int st, input logic [31:0] a, input logic [31:0] d);
    m_st = st; m_psel = m_sel; m_pen = 1'b0; m_pw = 1'b1;
    m_paddr = a; m_pwdata = d; m_rdy = 1'b0;
  endtask

  task automatic m_enable(input int st);
    m_st = st; m_pen = 1'b1; m_rdy = 1'b1;
  endtask

  // one clock edge of expected behaviour, from the inputs currently applied
  task automatic model_update();
    if (!hresetn) begin
      m_sel = 3'b000; m_pw = 1'b0; m_paddr = 32'h0; m_pwdata = 32'h0;
      m_bus_idle(M_IDLE);
    end else begin
      case (m_st)
        M_IDLE, M_REN, M_WEN: begin
          if (valid && hwrite) begin
            m_sel = tempselx;
            m_bus_idle(M_WWAIT);
          end else if (valid) m_start_read();
          else m_bus_idle(M_IDLE);
        end
        M_WWAIT: m_write_setup(valid ? M_WRP : M_WRITE, haddr_1, hwdata);
        M_READ:  m_enable(M_REN);
        M_WRITE: m_enable(valid ? M_WENP : M_WEN);
        M_WRP:   m_enable(M_WENP);
        M_WENP: begin
          if (!hwrite_reg) m_start_read();
          else m_write_setup(valid ? M_WRP : M_WRITE, haddr_2, hwdata_1);
        end
        default: m_bus_idle(M_IDLE);
      endcase
    end
  endtask

  // advance one cycle; AHB-side delay lines shift after the edge
  task automatic step();
    model_update();
    @(posedge hclk);
    #1;
    hwrite_reg = hwrite_d1;
    hwrite_d1  = hwrite;
    haddr_2    = haddr_1;
    haddr_1    = haddr;
    hwdata_1   = hwdata;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    step();
    step();
    total++;
    if (pselx !== 3'b000 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 32'h0 ||
        pwdata !== 32'h0 || hready_out !== 1'b1) begin
      bad++;
      $display("FAIL reset: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h rdy=%b want 000 0 0 0 0 1",
               pselx, penable, pwrite, paddr, pwdata, hready_out);
    end
    hresetn = 1'b1;
    idle(2);
  endtask

  task automatic test_single_read();
    haddr = 32'h8000_0010; valid = 1'b1; hwrite = 1'b0; tempselx = 3'b001;
    step();
    valid = 1'b0; haddr = 32'h0;
    total++;
    if (pselx !== 3'b001 || paddr !== 32'h8000_0010 || penable !== 1'b0 || pwrite !== 1'b0 || hready_out !== 1'b0) begin
      bad++;
      $display("FAIL read_setup: got psel=%b paddr=%h pen=%b pw=%b rdy=%b want 001 80000010 0 0 0",
               pselx, paddr, penable, pwrite, hready_out);
    end
    step();
    total++;
    if (pselx !== 3'b001 || penable !== 1'b1 || hready_out !== 1'b1) begin
      bad++;
      $display("FAIL read_enable: got psel=%b pen=%b rdy=%b want 001 1 1", pselx, penable, hready_out);
    end
    step();
    total++;
    if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1) begin
      bad++;
      $display("FAIL read_idle: got psel=%b pen=%b rdy=%b want 000 0 1", pselx, penable, hready_out);
    end
  endtask

  task automatic test_single_write();
    haddr = 32'h8400_0020; valid = 1'b1; hwrite = 1'b1; tempselx = 3'b010;
    step();
    valid = 1'b0; haddr = 32'h0; tempselx = 3'b000; hwdata = 32'hDEAD_BEEF;
    total++;
    if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1) begin
      bad++;
      $display("FAIL write_wait: got psel=%b pen=%b rdy=%b want 000 0 1", pselx, penable, hready_out);
    end
    step();
    hwdata = 32'h0;
    total++;
    if (pselx !== 3'b010 || pwrite !== 1'b1 || paddr !== 32'h8400_0020 || pwdata !== 32'hDEAD_BEEF ||
        penable !== 1'b0 || hready_out !== 1'b0) begin
      bad++;
      $display("FAIL write_setup: got psel=%b pw=%b paddr=%h pwdata=%h pen=%b rdy=%b want 010 1 84000020 deadbeef 0 0",
               pselx, pwrite, paddr, pwdata, penable, hready_out);
    end
    step();
    total++;
    if (penable !== 1'b1 || pselx !== 3'b010 || hready_out !== 1'b1 || pwdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL write_enable: got pen=%b psel=%b rdy=%b pwdata=%h want 1 010 1 deadbeef",
               penable, pselx, hready_out, pwdata);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    hwrite = 1'b1; valid = 1'b1; tempselx = 3'b100; haddr = 32'h8800_0000;
    step();                                 // WWAIT
    haddr = 32'h8800_0004; hwdata = 32'h1111_0000;
    step();                                 // WRITEP
    total++;
    if (paddr !== 32'h8800_0000 || pwdata !== 32'h1111_0000 || pselx !== 3'b100 || hready_out !== 1'b0 || penable !== 1'b0) begin
      bad++;
      $display("FAIL b2b_setup1: got paddr=%h pwdata=%h psel=%b rdy=%b pen=%b want 88000000 11110000 100 0 0",
               paddr, pwdata, pselx, hready_out, penable);
    end
    valid = 1'b0; hwdata = 32'h2222_0004;
    step();                                 // WENABLEP
    total++;
    if (penable !== 1'b1 || hready_out !== 1'b1 || paddr !== 32'h8800_0000) begin
      bad++;
      $display("FAIL b2b_enable1: got pen=%b rdy=%b paddr=%h want 1 1 88000000", penable, hready_out, paddr);
    end
    hwdata = 32'h0;
    step();                                 // WRITE
    total++;
    if (paddr !== 32'h8800_0004 || pwdata !== 32'h2222_0004 || hready_out !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b1) begin
      bad++;
      $display("FAIL b2b_setup2: got paddr=%h pwdata=%h rdy=%b pen=%b pw=%b want 88000004 22220004 0 0 1",
               paddr, pwdata, hready_out, penable, pwrite);
    end
    step();                                 // WENABLE
    total++;
    if (penable !== 1'b1 || hready_out !== 1'b1 || pselx !== 3'b100) begin
      bad++;
      $display("FAIL b2b_enable2: got pen=%b rdy=%b psel=%b want 1 1 100", penable, hready_out, pselx);
    end
    idle(4);
  endtask

  task automatic test_read_then_write();
    haddr = 32'h8000_0100; valid = 1'b1; hwrite = 1'b0; tempselx = 3'b001;
    step();                                 // READ
    haddr = 32'h8400_0200; hwrite = 1'b1; tempselx = 3'b010;
    step();                                 // RENABLE
    total++;
    if (pwrite !== 1'b0 || penable !== 1'b1 || pselx !== 3'b001 || paddr !== 32'h8000_0100) begin
      bad++;
      $display("FAIL rw_read: got pw=%b pen=%b psel=%b paddr=%h want 0 1 001 80000100", pwrite, penable, pselx, paddr);
    end
    step();                                 // WWAIT
    valid = 1'b0; hwdata = 32'hCAFE_F00D;
    step();                                 // WRITE
    total++;
    if (pwrite !== 1'b1 || pselx !== 3'b010 || paddr !== 32'h8400_0200 || pwdata !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL rw_write: got pw=%b psel=%b paddr=%h pwdata=%h want 1 010 84000200 cafef00d",
               pwrite, pselx, paddr, pwdata);
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    haddr = 32'h8400_0040; valid = 1'b1; hwrite = 1'b1; tempselx = 3'b010;
    step();
    valid = 1'b0; hwdata = 32'h5A5A_5A5A;
    step();
    step();                                 // WENABLE
    hresetn = 1'b0;
    step();
    total++;
    if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1 || paddr !== 32'h0 || pwrite !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got psel=%b pen=%b rdy=%b paddr=%h pw=%b want 000 0 1 0 0",
               pselx, penable, hready_out, paddr, pwrite);
    end
    hresetn = 1'b1;
    step();
    step();
    total++;
    if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1 || paddr !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold: got psel=%b pen=%b rdy=%b paddr=%h want 000 0 1 0", pselx, penable, hready_out, paddr);
    end
  endtask

  task automatic test_out_of_window();
    haddr = 32'h1234_5678; valid = 1'b1; hwrite = 1'b0; tempselx = 3'b000;
    step();
    valid = 1'b0;
    total++;
    if (pselx !== 3'b000 || hready_out !== 1'b0 || paddr !== 32'h1234_5678) begin
      bad++;
      $display("FAIL oow_setup: got psel=%b rdy=%b paddr=%h want 000 0 12345678", pselx, hready_out, paddr);
    end
    step();
    total++;
    if (pselx !== 3'b000 || penable !== 1'b1 || hready_out !== 1'b1) begin
      bad++;
      $display("FAIL oow_enable: got psel=%b pen=%b rdy=%b want 000 1 1", pselx, penable, hready_out);
    end
    idle(4);
  endtask

  task automatic test_random();
    logic [69:0] exp_v;
    logic [69:0] got_v;
    logic [2:0]  sels [4];
    sels[0] = 3'b000; sels[1] = 3'b001; sels[2] = 3'b010; sels[3] = 3'b100;
    for (int i = 0; i < 400; i++) begin
      hresetn  = ($urandom_range(0, 59) != 0);
      valid    = ($urandom_range(0, 3) != 0);
      hwrite   = $urandom_range(0, 1) == 1;
      haddr    = $urandom;
      hwdata   = $urandom;
      tempselx = sels[$urandom_range(0, 3)];
      step();
      exp_v = {m_psel, m_pen, m_pw, m_paddr, m_pwdata, m_rdy};
      got_v = {pselx, penable, pwrite, paddr, pwdata, hready_out};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL random[%0d]: got %h expected %h (psel,pen,pw,paddr,pwdata,rdy)", i, got_v, exp_v);
      end
      total++;
      if ($countones(pselx) > 1) begin
        bad++;
        $display("FAIL onehot[%0d]: got psel=%b expected at most one bit set", i, pselx);
      end
    end
    hresetn = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    hresetn = 1'b0; valid = 1'b0; hwrite = 1'b0; hwrite_reg = 1'b0; hwrite_d1 = 1'b0;
    haddr = 32'h0; haddr_1 = 32'h0; haddr_2 = 32'h0;
    hwdata = 32'h0; hwdata_1 = 32'h0; tempselx = 3'b000;
    m_st = M_IDLE; m_sel = 3'b000; m_psel = 3'b000; m_pen = 1'b0; m_pw = 1'b0;
    m_paddr = 32'h0; m_pwdata = 32'h0; m_rdy = 1'b1;
    #2;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_read_then_write();
    test_reset_mid();
    test_out_of_window();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
